// File: rtl/fu_alu_arbiter_if.sv
// Bundle of requester, functional-unit and result-port signals for fu_alu_arbiter.
// slave is the arbiter's view; master is the surrounding core (or bench).
interface fu_alu_arbiter_if #(
   parameter int N    = 4,
   parameter int TAGW = 5
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [4*N-1:0]    req_ctrl;
   logic [32*N-1:0]   req_a;
   logic [32*N-1:0]   req_b;
   logic [TAGW*N-1:0] req_tag;

   logic              fu_en;
   logic [3:0]        fu_ctrl;
   logic [31:0]       fu_a;
   logic [31:0]       fu_b;
   logic [31:0]       fu_res;
   logic              fu_zero;
   logic              fu_overflow;
   logic              fu_finish;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_res;
   logic              out_zero;
   logic              out_overflow;
   logic [TAGW-1:0]   out_tag;
   logic [SW-1:0]     out_src;
   logic              busy;
   logic              err;

   modport slave (
      input  req_valid, req_ctrl, req_a, req_b, req_tag,
      output req_ready,
      output fu_en, fu_ctrl, fu_a, fu_b,
      input  fu_res, fu_zero, fu_overflow, fu_finish,
      output out_valid, out_res, out_zero, out_overflow, out_tag, out_src, busy, err,
      input  out_ready
   );

   modport master (
      output req_valid, req_ctrl, req_a, req_b, req_tag,
      input  req_ready,
      input  fu_en, fu_ctrl, fu_a, fu_b,
      output fu_res, fu_zero, fu_overflow, fu_finish,
      input  out_valid, out_res, out_zero, out_overflow, out_tag, out_src, busy, err,
      output out_ready
   );
endinterface

// File: rtl/fu_alu_arbiter.sv
// Round-robin arbiter sharing one two-cycle ALU between N requesters; pulses the FU
// enable once per operation and returns the result with its tag on a valid/ready port.
module fu_alu_arbiter #(
   parameter int N       = 4,
   parameter int TAGW    = 5,
   parameter int TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   fu_alu_arbiter_if.slave  bus
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   ptr_q, ptr_d;
   logic [SW-1:0]   src_q, src_d;
   logic [SW-1:0]   out_src_q, out_src_d;
   logic [3:0]      ctrl_q, ctrl_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic [TAGW-1:0] tag_q, tag_d;
   logic [TAGW-1:0] out_tag_q, out_tag_d;
   logic [31:0]     res_q, res_d;
   logic            zero_q, zero_d;
   logic            ovf_q, ovf_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            fu_en_q, busy_q, out_valid_q;

   logic            any_valid_s;
   logic [SW-1:0]   grant_idx_s;
   logic [N-1:0]    grant_oh_s;
   logic            grant_s;
   logic [N-1:0]    req_ready_s;

   // Round-robin pick: loop runs from the farthest offset down so the nearest valid wins.
   always_comb begin : rr_pick
      int idx_v;
      idx_v       = 0;
      grant_idx_s = ptr_q;
      for (int k = N; k >= 1; k--) begin
         idx_v       = (int'(ptr_q) + k) % N;
         grant_idx_s = bus.req_valid[idx_v] ? idx_v[SW-1:0] : grant_idx_s;
      end
      any_valid_s = |bus.req_valid;
      grant_oh_s  = {{(N-1){1'b0}}, 1'b1} << grant_idx_s;
   end

   // Next-state, grant and capture logic.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      src_d       = src_q;
      out_src_d   = out_src_q;
      ctrl_d      = ctrl_q;
      a_d         = a_q;
      b_d         = b_q;
      tag_d       = tag_q;
      out_tag_d   = out_tag_q;
      res_d       = res_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      grant_s     = 1'b0;
      req_ready_s = '0;

      case (state_q)
         S_IDLE: begin
            if (any_valid_s) begin
               grant_s = 1'b1;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.fu_finish) begin
               res_d     = bus.fu_res;
               zero_d    = bus.fu_zero;
               ovf_d     = bus.fu_overflow;
               out_tag_d = tag_q;
               out_src_d = src_q;
               state_d   = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // FU never answered: flag it and drop the operation.
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (bus.out_ready && any_valid_s) begin
               grant_s = 1'b1;
               state_d = S_ISSUE;
            end else if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (grant_s) begin
         req_ready_s = grant_oh_s;
         ptr_d       = grant_idx_s;
         src_d       = grant_idx_s;
         ctrl_d      = bus.req_ctrl[int'(grant_idx_s) * 4 +: 4];
         a_d         = bus.req_a[int'(grant_idx_s) * 32 +: 32];
         b_d         = bus.req_b[int'(grant_idx_s) * 32 +: 32];
         tag_d       = bus.req_tag[int'(grant_idx_s) * TAGW +: TAGW];
      end else begin
         req_ready_s = '0;
      end
   end

   // State and datapath registers; decoded outputs are registered from next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= SW'(N - 1);
         src_q       <= '0;
         out_src_q   <= '0;
         ctrl_q      <= 4'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         tag_q       <= '0;
         out_tag_q   <= '0;
         res_q       <= 32'd0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         fu_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         src_q       <= src_d;
         out_src_q   <= out_src_d;
         ctrl_q      <= ctrl_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tag_q       <= tag_d;
         out_tag_q   <= out_tag_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         fu_en_q     <= (state_d == S_ISSUE);
         busy_q      <= (state_d != S_IDLE);
         out_valid_q <= (state_d == S_DONE);
      end
   end

   assign bus.req_ready    = req_ready_s;
   assign bus.fu_en        = fu_en_q;
   assign bus.fu_ctrl      = ctrl_q;
   assign bus.fu_a         = a_q;
   assign bus.fu_b         = b_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_res      = res_q;
   assign bus.out_zero     = zero_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_tag      = out_tag_q;
   assign bus.out_src      = out_src_q;
   assign bus.busy         = busy_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_fu_alu_arbiter.sv
// Directed bench for fu_alu_arbiter: a vector table of single operations plus
// hand-written round-robin, backpressure, timeout and mid-operation reset sequences.
module tb_fu_alu_arbiter;
   localparam int N = 4, TAGW = 5, TIMEOUT = 4;
   localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0110, XOR = 4'b0101, SLT = 4'b1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fu_alu_arbiter_if #(.N(N), .TAGW(TAGW)) bus ();
   fu_alu_arbiter #(.N(N), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural two-cycle FU: finish with the result in the cycle after fu_en.
   bit   fu_alive = 1'b1;
   bit   stray    = 1'b0;
   logic en_seen  = 1'b0;

   function automatic logic [33:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (c)
         ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         XOR: r = a ^ b;
         SLT: r = {31'd0, ($signed(a) < $signed(b))};
         default: r = 32'hDEADBEEF;
      endcase
      return {(r == 32'd0), v, r};
   endfunction

   always @(negedge clk) en_seen = bus.fu_en;

   always @(posedge clk) begin
      logic [33:0] r;
      #1;
      if ((en_seen && fu_alive) || stray) begin
         r = stray ? {2'b00, 32'hDEADBEEF} : alu(bus.fu_ctrl, bus.fu_a, bus.fu_b);
         bus.fu_finish   = 1'b1;
         bus.fu_res      = r[31:0];
         bus.fu_overflow = r[32];
         bus.fu_zero     = r[33];
      end else begin
         bus.fu_finish = 1'b0;
      end
   end

   typedef struct {
      int         src;
      logic [3:0] ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0] tag;
      logic [31:0] res;
      logic       zero;
      logic       ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t);
      bus.req_ctrl[i*4 +: 4]   = c;
      bus.req_a[i*32 +: 32]    = a;
      bus.req_b[i*32 +: 32]    = b;
      bus.req_tag[i*TAGW +: TAGW] = t;
   endtask

   // Starts at a negedge with the DUT idle and out_ready high; ends at a negedge, idle.
   task automatic run_single(input vec_t v, input string nm);
      set_req(v.src, v.ctrl, v.a, v.b, v.tag);
      bus.req_valid = 4'b0001 << v.src;
      #1;
      check({nm, "_grant"}, bus.req_ready, 4'b0001 << v.src);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      check({nm, "_fu_en_on"}, bus.fu_en, 1'b1);
      check({nm, "_ready_off"}, bus.req_ready, 4'b0000);
      @(negedge clk);
      check({nm, "_fu_en_off"}, bus.fu_en, 1'b0);
      check({nm, "_early_valid"}, bus.out_valid, 1'b0);
      @(negedge clk);
      check({nm, "_out_valid"}, bus.out_valid, 1'b1);
      check({nm, "_res"}, bus.out_res, v.res);
      check({nm, "_zero"}, bus.out_zero, v.zero);
      check({nm, "_ovf"}, bus.out_overflow, v.ovf);
      check({nm, "_tag"}, bus.out_tag, v.tag);
      check({nm, "_src"}, bus.out_src, v.src[1:0]);
      @(negedge clk);
      check({nm, "_valid_drop"}, bus.out_valid, 1'b0);
      check({nm, "_idle"}, bus.busy, 1'b0);
   endtask

   logic [31:0] rr_a[4]   = '{32'd10, 32'h80000000, 32'd5, 32'd0};
   logic [31:0] rr_b[4]   = '{32'd3, 32'd1, 32'd5, 32'd1};
   logic [31:0] rr_res[4] = '{32'd7, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF};
   logic        rr_ovf[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic        rr_zero[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      vecs[0] = '{0, ADD, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b0};
      vecs[1] = '{2, SLT, 32'hFFFFFFFF, 32'd1, 5'd7, 32'd1, 1'b0, 1'b0};
      vecs[2] = '{1, XOR, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'h1F, 32'd0, 1'b1, 1'b0};
      vecs[3] = '{3, ADD, 32'h7FFFFFFF, 32'd1, 5'd9, 32'h80000000, 1'b0, 1'b1};
      vecs[4] = '{0, SUB, 32'h80000000, 32'd1, 5'd2, 32'h7FFFFFFF, 1'b0, 1'b1};

      bus.req_valid = '0;
      bus.req_ctrl  = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_tag   = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_ready", bus.req_ready, 4'b0000);
      check("rst_fu_en", bus.fu_en, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_fu_ctrl", bus.fu_ctrl, 4'd0);
      check("rst_fu_a", bus.fu_a, 32'd0);
      check("rst_fu_b", bus.fu_b, 32'd0);
      check("rst_out_res", bus.out_res, 32'd0);
      check("rst_out_tag", bus.out_tag, 5'd0);
      check("rst_out_src", bus.out_src, 2'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // All four requesters valid: grants 0,1,2,3,0 with one result every 3 cycles.
      for (int i = 0; i < 4; i++) set_req(i, SUB, rr_a[i], rr_b[i], 5'(10 + i));
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         int s;
         s = k % 4;
         #1;
         check("rr_grant", bus.req_ready, 4'b0001 << s);
         @(negedge clk);
         check("rr_fu_en", bus.fu_en, 1'b1);
         @(negedge clk);
         @(negedge clk);
         check("rr_out_valid", bus.out_valid, 1'b1);
         check("rr_src", bus.out_src, s[1:0]);
         check("rr_res", bus.out_res, rr_res[s]);
         check("rr_ovf", bus.out_overflow, rr_ovf[s]);
         check("rr_zero", bus.out_zero, rr_zero[s]);
         check("rr_tag", bus.out_tag, 5'(10 + s));
         if (k == 4) bus.req_valid = 4'b0000;
      end
      @(negedge clk);
      check("rr_drain_valid", bus.out_valid, 1'b0);
      check("rr_drain_busy", bus.busy, 1'b0);

      for (int i = 0; i < 5; i++) run_single(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result held in DONE, waiting requester not granted until release.
      bus.out_ready = 1'b0;
      set_req(2, ADD, 32'd1, 32'd2, 5'd4);
      bus.req_valid = 4'b0100;
      #1;
      check("bp_grant2", bus.req_ready, 4'b0100);
      @(negedge clk);
      set_req(1, XOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd6);
      bus.req_valid = 4'b0010;
      check("bp_issue_ready", bus.req_ready, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         check("bp_hold_valid", bus.out_valid, 1'b1);
         check("bp_hold_res", bus.out_res, 32'd3);
         check("bp_hold_ready", bus.req_ready, 4'b0000);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_grant", bus.req_ready, 4'b0010);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      check("bp_valid_drop", bus.out_valid, 1'b0);
      check("bp_fu_en", bus.fu_en, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("bp_next_res", bus.out_res, 32'hFFFFFFFF);
      check("bp_next_src", bus.out_src, 2'd1);
      check("bp_next_tag", bus.out_tag, 5'd6);
      @(negedge clk);

      // Timeout: FU silent for TIMEOUT WAIT cycles.
      fu_alive = 1'b0;
      set_req(3, ADD, 32'd1, 32'd1, 5'd2);
      bus.req_valid = 4'b1000;
      #1;
      check("to_grant", bus.req_ready, 4'b1000);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      repeat (4) @(negedge clk);
      check("to_err_before", bus.err, 1'b0);
      check("to_busy_wait", bus.busy, 1'b1);
      @(negedge clk);
      check("to_err", bus.err, 1'b1);
      check("to_idle", bus.busy, 1'b0);
      check("to_no_valid", bus.out_valid, 1'b0);
      fu_alive = 1'b1;
      run_single(vecs[0], "to_after");
      check("to_err_sticky", bus.err, 1'b1);

      // Reset in WAIT, then a stray finish in IDLE, then priority back at requester 0.
      set_req(1, ADD, 32'd10, 32'd20, 5'd5);
      bus.req_valid = 4'b0010;
      @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mr_busy", bus.busy, 1'b0);
      check("mr_fu_en", bus.fu_en, 1'b0);
      check("mr_err", bus.err, 1'b0);
      check("mr_fu_a", bus.fu_a, 32'd0);
      check("mr_fu_ctrl", bus.fu_ctrl, 4'd0);
      check("mr_out_res", bus.out_res, 32'd0);
      check("mr_out_valid", bus.out_valid, 1'b0);
      check("mr_ready", bus.req_ready, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      check("mr_stray_busy", bus.busy, 1'b0);
      @(negedge clk);
      check("mr_stray_valid", bus.out_valid, 1'b0);
      check("mr_stray_res", bus.out_res, 32'd0);
      set_req(0, ADD, 32'd100, 32'd23, 5'd1);
      bus.req_valid = 4'b1111;
      #1;
      check("mr_first_grant", bus.req_ready, 4'b0001);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      check("mr_res", bus.out_res, 32'd123);
      check("mr_src", bus.out_src, 2'd0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
